// File: rtl/apb_watch_pkg.sv
// Shared register map, command/mode/status bit positions and offset decoder
// for the multi-channel APB stopwatch.
package apb_watch_pkg;

  localparam logic [7:0] OFF_CMD  = 8'h00;
  localparam logic [7:0] OFF_MODE = 8'h04;
  localparam logic [7:0] OFF_LOAD = 8'h08;
  localparam logic [7:0] OFF_CURR = 8'h0C;
  localparam logic [7:0] OFF_LAP  = 8'h10;
  localparam logic [7:0] OFF_STAT = 8'h14;

  localparam int CMD_START = 0;
  localparam int CMD_STOP  = 1;
  localparam int CMD_RESET = 2;
  localparam int CMD_STORE = 3;

  localparam int MODE_DOWN   = 0;
  localparam int MODE_IRQ_EN = 1;

  localparam int STAT_RUNNING   = 0;
  localparam int STAT_EMPTY     = 1;
  localparam int STAT_FULL      = 2;
  localparam int STAT_OVF       = 3;
  localparam int STAT_EXPIRED   = 4;
  localparam int STAT_COUNT_LSB = 8;

  typedef enum logic [2:0] {
    REG_CMD,
    REG_MODE,
    REG_LOAD,
    REG_CURR,
    REG_LAP,
    REG_STAT,
    REG_NONE
  } reg_sel_e;

  function automatic reg_sel_e decode_reg(input logic [7:0] offset);
    reg_sel_e r;
    r = REG_NONE;
    case (offset)
      OFF_CMD:  r = REG_CMD;
      OFF_MODE: r = REG_MODE;
      OFF_LOAD: r = REG_LOAD;
      OFF_CURR: r = REG_CURR;
      OFF_LAP:  r = REG_LAP;
      OFF_STAT: r = REG_STAT;
      default:  r = REG_NONE;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/watch_channel.sv
// One stopwatch channel: 10 ms prescaler, 32-bit up/down counter,
// lap FIFO with overflow flag, and down-count expiry flag.
module watch_channel
  import apb_watch_pkg::*;
#(
  parameter int LAP_DEPTH = 16,
  parameter int CLK_DIV   = 1000000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cmd_we,
  input  logic [3:0]  cmd,
  input  logic        mode_we,
  input  logic [1:0]  mode_wdata,
  input  logic        load_we,
  input  logic [3:0]  load_strb,
  input  logic [31:0] load_wdata,
  input  logic        clr_ovf,
  input  logic        clr_expired,
  input  logic        lap_pop,
  output logic [31:0] count,
  output logic [1:0]  mode,
  output logic [31:0] load,
  output logic        running,
  output logic        lap_empty,
  output logic        lap_full,
  output logic        lap_ovf,
  output logic        expired,
  output logic [7:0]  lap_count,
  output logic [31:0] lap_data
);

  localparam int PW  = $clog2(LAP_DEPTH);
  localparam int PSW = $clog2(CLK_DIV);
  localparam logic [PSW-1:0] PRESC_MAX = PSW'(CLK_DIV - 1);
  localparam logic [PW:0]    FIFO_FULL = (PW + 1)'(LAP_DEPTH);

  logic [PSW-1:0] presc;
  logic [PW:0]    fifo_cnt;
  logic [PW-1:0]  wr_ptr, rd_ptr, wr_idx;
  logic [31:0]    mem [LAP_DEPTH];

  logic        do_start, do_stop, do_reset, do_store;
  logic        tick, expire, running_nxt, push, pop;
  logic [31:0] reset_val, count_nxt, store_val;

  // Reset beats a coincident tick; stop beats start; start is judged on the
  // post-update count so a down-mode channel sitting at zero refuses to run.
  always_comb begin
    do_start  = cmd_we & cmd[CMD_START];
    do_stop   = cmd_we & cmd[CMD_STOP];
    do_reset  = cmd_we & cmd[CMD_RESET];
    do_store  = cmd_we & cmd[CMD_STORE];
    reset_val = mode[MODE_DOWN] ? load : 32'd0;
    tick      = running & (presc == PRESC_MAX);
    expire    = tick & mode[MODE_DOWN] & (count == 32'd1) & ~do_reset;

    count_nxt = count;
    if (do_reset)  count_nxt = reset_val;
    else if (tick) count_nxt = mode[MODE_DOWN] ? count - 32'd1 : count + 32'd1;

    running_nxt = running;
    if (do_stop)       running_nxt = 1'b0;
    else if (do_start) running_nxt = ~(mode[MODE_DOWN] & (count_nxt == 32'd0));
    else if (expire)   running_nxt = 1'b0;

    lap_empty = (fifo_cnt == '0);
    lap_full  = (fifo_cnt == FIFO_FULL);
    push      = do_store & (do_reset | ~lap_full);
    pop       = lap_pop & ~lap_empty;
    store_val = do_reset ? reset_val : count;
    wr_idx    = do_reset ? '0 : wr_ptr;
    lap_count = 8'(fifo_cnt);
    lap_data  = lap_empty ? 32'd0 : mem[rd_ptr];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      presc   <= '0;
      count   <= 32'd0;
      running <= 1'b0;
      expired <= 1'b0;
      lap_ovf <= 1'b0;
    end else begin
      count   <= count_nxt;
      running <= running_nxt;
      if (do_reset)     presc <= '0;
      else if (running) presc <= (presc == PRESC_MAX) ? '0 : presc + PSW'(1);
      if (clr_expired) expired <= 1'b0;
      if (expire)      expired <= 1'b1;
      if (do_reset | clr_ovf)               lap_ovf <= 1'b0;
      if (do_store & ~do_reset & lap_full)  lap_ovf <= 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mode <= 2'd0;
      load <= 32'd0;
    end else begin
      if (mode_we) mode <= mode_wdata;
      if (load_we) begin
        for (int b = 0; b < 4; b++)
          if (load_strb[b]) load[8*b +: 8] <= load_wdata[8*b +: 8];
      end
    end
  end

  // A reset command flushes the FIFO; a store in the same write lands in slot 0.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      fifo_cnt <= '0;
    end else if (do_reset) begin
      wr_ptr   <= push ? PW'(1) : '0;
      rd_ptr   <= '0;
      fifo_cnt <= push ? (PW + 1)'(1) : '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
      case ({push, pop})
        2'b10:   fifo_cnt <= fifo_cnt + (PW + 1)'(1);
        2'b01:   fifo_cnt <= fifo_cnt - (PW + 1)'(1);
        default: fifo_cnt <= fifo_cnt;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_idx] <= store_val;
  end

endmodule

// File: rtl/apb_watch_mc.sv
// Multi-channel APB stopwatch/timer slave: address decode, per-channel
// strobes, read mux, slave error and interrupt combine.
module apb_watch_mc
  import apb_watch_pkg::*;
#(
  parameter int NUM_CH    = 4,
  parameter int LAP_DEPTH = 16,
  parameter int CLK_DIV   = 1000000
) (
  input  logic              iPCLK,
  input  logic              iPRESET,
  input  logic              iPSEL,
  input  logic              iPENABLE,
  input  logic              iPWRITE,
  input  logic [3:0]        iPSTRB,
  input  logic [15:0]       iPADDR,
  input  logic [31:0]       iPWDATA,
  output logic [31:0]       oPRDATA,
  output logic              oPREADY,
  output logic              oPSLVERR,
  output logic              oIRQ,
  output logic [NUM_CH-1:0] oRUNNING
);

  logic [3:0] ch;
  reg_sel_e   sel;
  logic       access, err, wr_ok, rd_ok;

  logic [NUM_CH-1:0] ch_running, ch_empty, ch_full, ch_ovf, ch_expired, ch_irq;
  logic [31:0]       ch_count    [NUM_CH];
  logic [31:0]       ch_load     [NUM_CH];
  logic [31:0]       ch_lap_data [NUM_CH];
  logic [1:0]        ch_mode     [NUM_CH];
  logic [7:0]        ch_lap_count[NUM_CH];

  // Any error blocks both the write strobes and the read data/pop path.
  always_comb begin
    ch     = iPADDR[11:8];
    sel    = decode_reg(iPADDR[7:0]);
    access = iPSEL & iPENABLE;
    err    = (iPADDR[15:12] != 4'd0) || (int'(ch) >= NUM_CH) || (sel == REG_NONE) ||
             (iPWRITE && (sel == REG_CURR || sel == REG_LAP));
    wr_ok  = access & iPWRITE & ~err;
    rd_ok  = access & ~iPWRITE & ~err;
  end

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    logic hit, wr_b0;
    assign hit   = (int'(ch) == g);
    assign wr_b0 = wr_ok & hit & iPSTRB[0];

    watch_channel #(
      .LAP_DEPTH(LAP_DEPTH),
      .CLK_DIV  (CLK_DIV)
    ) u_channel (
      .clk        (iPCLK),
      .rst        (iPRESET),
      .cmd_we     (wr_b0 && sel == REG_CMD),
      .cmd        (iPWDATA[3:0]),
      .mode_we    (wr_b0 && sel == REG_MODE),
      .mode_wdata (iPWDATA[1:0]),
      .load_we    (wr_ok && hit && sel == REG_LOAD),
      .load_strb  (iPSTRB),
      .load_wdata (iPWDATA),
      .clr_ovf    (wr_b0 && sel == REG_STAT && iPWDATA[STAT_OVF]),
      .clr_expired(wr_b0 && sel == REG_STAT && iPWDATA[STAT_EXPIRED]),
      .lap_pop    (rd_ok && hit && sel == REG_LAP),
      .count      (ch_count[g]),
      .mode       (ch_mode[g]),
      .load       (ch_load[g]),
      .running    (ch_running[g]),
      .lap_empty  (ch_empty[g]),
      .lap_full   (ch_full[g]),
      .lap_ovf    (ch_ovf[g]),
      .expired    (ch_expired[g]),
      .lap_count  (ch_lap_count[g]),
      .lap_data   (ch_lap_data[g])
    );

    assign ch_irq[g] = ch_expired[g] & ch_mode[g][MODE_IRQ_EN];
  end

  always_comb begin
    oPRDATA = 32'd0;
    if (rd_ok) begin
      for (int i = 0; i < NUM_CH; i++) begin
        if (int'(ch) == i) begin
          case (sel)
            REG_MODE: oPRDATA = {30'd0, ch_mode[i]};
            REG_LOAD: oPRDATA = ch_load[i];
            REG_CURR: oPRDATA = ch_count[i];
            REG_LAP:  oPRDATA = ch_lap_data[i];
            REG_STAT: begin
              oPRDATA[STAT_RUNNING]                  = ch_running[i];
              oPRDATA[STAT_EMPTY]                    = ch_empty[i];
              oPRDATA[STAT_FULL]                     = ch_full[i];
              oPRDATA[STAT_OVF]                      = ch_ovf[i];
              oPRDATA[STAT_EXPIRED]                  = ch_expired[i];
              oPRDATA[STAT_COUNT_LSB +: 8]           = ch_lap_count[i];
            end
            default:  oPRDATA = 32'd0;
          endcase
        end
      end
    end
  end

  assign oPSLVERR = access & err;
  assign oPREADY  = 1'b1;
  assign oIRQ     = |ch_irq;
  assign oRUNNING = ch_running;

endmodule

// File: tb/tb_apb_watch_mc.sv
// Scenario bench for apb_watch_mc (4 channels, 4-deep laps, 4-cycle tick):
// expected read results are queued as each access is issued and checked on return.
module tb_apb_watch_mc;
  import apb_watch_pkg::*;

  localparam int NUM_CH    = 4;
  localparam int LAP_DEPTH = 4;
  localparam int CLK_DIV   = 4;

  logic        iPCLK = 1'b0;
  logic        iPRESET, iPSEL, iPENABLE, iPWRITE;
  logic [3:0]  iPSTRB;
  logic [15:0] iPADDR;
  logic [31:0] iPWDATA;
  logic [31:0] oPRDATA;
  logic        oPREADY, oPSLVERR, oIRQ;
  logic [NUM_CH-1:0] oRUNNING;

  typedef struct {
    string       name;
    logic [31:0] data;
    logic        err;
  } exp_t;

  exp_t exp_q[$];
  int   checks   = 0;
  int   failures = 0;

  apb_watch_mc #(
    .NUM_CH   (NUM_CH),
    .LAP_DEPTH(LAP_DEPTH),
    .CLK_DIV  (CLK_DIV)
  ) dut (
    .iPCLK   (iPCLK),
    .iPRESET (iPRESET),
    .iPSEL   (iPSEL),
    .iPENABLE(iPENABLE),
    .iPWRITE (iPWRITE),
    .iPSTRB  (iPSTRB),
    .iPADDR  (iPADDR),
    .iPWDATA (iPWDATA),
    .oPRDATA (oPRDATA),
    .oPREADY (oPREADY),
    .oPSLVERR(oPSLVERR),
    .oIRQ    (oIRQ),
    .oRUNNING(oRUNNING)
  );

  always #5 iPCLK = ~iPCLK;

  function automatic logic [15:0] ra(input int c, input logic [7:0] off);
    return {4'h0, 4'(c), off};
  endfunction

  // Both transfers start 1 ns after an edge, commit on the second edge after.
  task automatic apb_write(input logic [15:0] addr, input logic [31:0] data,
                           output logic err, input logic [3:0] strb = 4'hF);
    iPSEL = 1'b1; iPENABLE = 1'b0; iPWRITE = 1'b1;
    iPADDR = addr; iPWDATA = data; iPSTRB = strb;
    @(posedge iPCLK); #1 iPENABLE = 1'b1;
    #1 err = oPSLVERR;
    @(posedge iPCLK); #1 iPSEL = 1'b0; iPENABLE = 1'b0; iPWRITE = 1'b0;
  endtask

  task automatic apb_read(input logic [15:0] addr, output logic [31:0] data, output logic err);
    iPSEL = 1'b1; iPENABLE = 1'b0; iPWRITE = 1'b0; iPADDR = addr;
    @(posedge iPCLK); #1 iPENABLE = 1'b1;
    #1 data = oPRDATA; err = oPSLVERR;
    @(posedge iPCLK); #1 iPSEL = 1'b0; iPENABLE = 1'b0;
  endtask

  task automatic test_reset();
    logic [31:0] rd; logic er; exp_t e;
    iPRESET = 1'b1; iPSEL = 1'b0; iPENABLE = 1'b0; iPWRITE = 1'b0;
    iPSTRB = 4'h0; iPADDR = 16'h0; iPWDATA = 32'h0;
    repeat (3) @(posedge iPCLK);
    #1 iPRESET = 1'b0;
    checks++; if (oPREADY !== 1'b1) begin failures++; $display("[TB] FAIL reset_pready: got %b, want 1", oPREADY); end
    checks++; if (oIRQ !== 1'b0) begin failures++; $display("[TB] FAIL reset_irq: got %b, want 0", oIRQ); end
    checks++; if (oRUNNING !== 4'b0000) begin failures++; $display("[TB] FAIL reset_running: got %b, want 0000", oRUNNING); end
    checks++; if (oPRDATA !== 32'd0 || oPSLVERR !== 1'b0) begin failures++; $display("[TB] FAIL reset_idle_bus: got data=%h err=%b, want 0/0", oPRDATA, oPSLVERR); end
    for (int c = 0; c < NUM_CH; c++) begin
      for (int k = 0; k < 2; k++) begin
        e.name = $sformatf("reset_%s%0d", (k == 0) ? "curr" : "stat", c);
        e.data = (k == 0) ? 32'd0 : 32'h2;
        e.err  = 1'b0;
        exp_q.push_back(e);
        apb_read(ra(c, (k == 0) ? OFF_CURR : OFF_STAT), rd, er);
        e = exp_q.pop_front();
        checks++;
        if (rd !== e.data || er !== e.err) begin failures++; $display("[TB] FAIL %s: got data=%h err=%b, want data=%h err=%b", e.name, rd, er, e.data, e.err); end
      end
    end
  endtask

  task automatic test_up_count();
    logic [31:0] rd; logic er; exp_t e;
    logic [15:0] addrs [5];
    logic [31:0] vals  [5];
    addrs = '{ra(0, OFF_CURR), ra(1, OFF_CURR), ra(2, OFF_CURR), ra(3, OFF_CURR), ra(1, OFF_STAT)};
    vals  = '{32'd0, 32'd10, 32'd0, 32'd0, 32'h2};
    apb_write(ra(1, OFF_CMD), 32'h1, er);
    checks++; if (er !== 1'b0) begin failures++; $display("[TB] FAIL up_start_err: got %b, want 0", er); end
    checks++; if (oRUNNING !== 4'b0010) begin failures++; $display("[TB] FAIL up_running: got %b, want 0010", oRUNNING); end
    repeat (40) @(posedge iPCLK);
    #1 apb_write(ra(1, OFF_CMD), 32'h2, er);
    checks++; if (oRUNNING !== 4'b0000) begin failures++; $display("[TB] FAIL up_stopped: got %b, want 0000", oRUNNING); end
    for (int i = 0; i < 5; i++) begin
      e.name = $sformatf("up_read%0d", i); e.data = vals[i]; e.err = 1'b0;
      exp_q.push_back(e);
    end
    for (int i = 0; i < 5; i++) begin
      apb_read(addrs[i], rd, er);
      e = exp_q.pop_front();
      checks++;
      if (rd !== e.data || er !== e.err) begin failures++; $display("[TB] FAIL %s: got data=%h err=%b, want data=%h err=%b", e.name, rd, er, e.data, e.err); end
    end
  endtask

  task automatic test_lap_fifo();
    logic [31:0] rd; logic er; exp_t e;
    logic [15:0] addrs [9];
    logic [31:0] vals  [9];
    addrs = '{ra(0, OFF_STAT), ra(0, OFF_LAP), ra(0, OFF_LAP), ra(0, OFF_LAP), ra(0, OFF_LAP),
              ra(0, OFF_LAP), ra(0, OFF_STAT), ra(0, OFF_LAP), ra(0, OFF_STAT)};
    vals  = '{32'h40C, 32'd1, 32'd2, 32'd3, 32'd4, 32'd0, 32'h0A, 32'd0, 32'h0A};
    apb_write(ra(0, OFF_CMD), 32'h1, er);
    repeat (4) @(posedge iPCLK);
    #1 apb_write(ra(0, OFF_CMD), 32'h8, er);
    for (int i = 0; i < 4; i++) begin
      repeat (2) @(posedge iPCLK);
      #1 apb_write(ra(0, OFF_CMD), 32'h8, er);
    end
    apb_write(ra(0, OFF_CMD), 32'h2, er);
    for (int i = 0; i < 9; i++) begin
      e.name = $sformatf("lap_read%0d", i); e.data = vals[i]; e.err = 1'b0;
      exp_q.push_back(e);
      apb_read(addrs[i], rd, er);
      e = exp_q.pop_front();
      checks++;
      if (rd !== e.data || er !== e.err) begin failures++; $display("[TB] FAIL %s: got data=%h err=%b, want data=%h err=%b", e.name, rd, er, e.data, e.err); end
    end
    apb_write(ra(0, OFF_STAT), 32'h08, er);
    apb_read(ra(0, OFF_STAT), rd, er);
    checks++; if (rd !== 32'h2) begin failures++; $display("[TB] FAIL lap_ovf_clear: got %h, want 00000002", rd); end
  endtask

  task automatic test_count_down();
    logic [31:0] rd; logic er; exp_t e;
    logic [15:0] addrs [5];
    logic [31:0] vals  [5];
    apb_write(ra(2, OFF_MODE), 32'h3, er);
    apb_write(ra(2, OFF_LOAD), 32'h3, er);
    apb_write(ra(2, OFF_CMD), 32'h4, er);
    apb_write(ra(2, OFF_CMD), 32'h1, er);
    for (int i = 0; i < 4; i++) begin
      e.name = $sformatf("down_curr_step%0d", i); e.data = 32'(3 - i); e.err = 1'b0;
      exp_q.push_back(e);
      apb_read(ra(2, OFF_CURR), rd, er);
      e = exp_q.pop_front();
      checks++;
      if (rd !== e.data || er !== e.err) begin failures++; $display("[TB] FAIL %s: got data=%h err=%b, want data=%h err=%b", e.name, rd, er, e.data, e.err); end
      repeat (2) @(posedge iPCLK);
      #1;
    end
    checks++; if (oRUNNING[2] !== 1'b0) begin failures++; $display("[TB] FAIL down_running: got %b, want 0", oRUNNING[2]); end
    checks++; if (oIRQ !== 1'b1) begin failures++; $display("[TB] FAIL down_irq_set: got %b, want 1", oIRQ); end
    apb_write(ra(2, OFF_CMD), 32'h1, er);
    checks++; if (oRUNNING[2] !== 1'b0) begin failures++; $display("[TB] FAIL down_start_at_zero: got %b, want 0", oRUNNING[2]); end
    addrs = '{ra(2, OFF_STAT), ra(2, OFF_MODE), ra(2, OFF_LOAD), ra(2, OFF_CURR), ra(2, OFF_STAT)};
    vals  = '{32'h12, 32'h3, 32'h3, 32'h0, 32'h12};
    for (int i = 0; i < 5; i++) begin
      e.name = $sformatf("down_read%0d", i); e.data = vals[i]; e.err = 1'b0;
      exp_q.push_back(e);
      apb_read(addrs[i], rd, er);
      e = exp_q.pop_front();
      checks++;
      if (rd !== e.data || er !== e.err) begin failures++; $display("[TB] FAIL %s: got data=%h err=%b, want data=%h err=%b", e.name, rd, er, e.data, e.err); end
    end
    apb_write(ra(2, OFF_STAT), 32'h10, er);
    checks++; if (oIRQ !== 1'b0) begin failures++; $display("[TB] FAIL down_irq_clear: got %b, want 0", oIRQ); end
    // Partial LOAD write, then reset+store in one command: the lap holds the reload value.
    apb_write(ra(2, OFF_LOAD), 32'hAABB_CCDD, er, 4'b0101);
    apb_write(ra(2, OFF_CMD), 32'hC, er);
    addrs = '{ra(2, OFF_LOAD), ra(2, OFF_CURR), ra(2, OFF_STAT), ra(2, OFF_LAP), ra(2, OFF_STAT)};
    vals  = '{32'h00BB_00DD, 32'h00BB_00DD, 32'h100, 32'h00BB_00DD, 32'h2};
    for (int i = 0; i < 5; i++) begin
      e.name = $sformatf("combo_read%0d", i); e.data = vals[i]; e.err = 1'b0;
      exp_q.push_back(e);
      apb_read(addrs[i], rd, er);
      e = exp_q.pop_front();
      checks++;
      if (rd !== e.data || er !== e.err) begin failures++; $display("[TB] FAIL %s: got data=%h err=%b, want data=%h err=%b", e.name, rd, er, e.data, e.err); end
    end
  endtask

  task automatic test_errors();
    logic [31:0] rd; logic er; exp_t e;
    logic        is_wr [11];
    logic [15:0] addrs [11];
    logic [31:0] wdat  [11];
    logic [31:0] vals  [11];
    logic        errs  [11];
    is_wr = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    addrs = '{16'h0400, 16'h010C, 16'h010C, 16'h1104, 16'h0104, 16'h0100,
              16'h1110, 16'h0020, 16'h0110, 16'h0110, 16'h0114};
    wdat  = '{32'h0, 32'h5, 32'h0, 32'h3, 32'h0, 32'h8, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0};
    vals  = '{32'h0, 32'h0, 32'd10, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'd10, 32'h0, 32'h2};
    errs  = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0};
    for (int i = 0; i < 11; i++) begin
      e.name = $sformatf("err_access%0d_%h", i, addrs[i]); e.data = vals[i]; e.err = errs[i];
      exp_q.push_back(e);
      if (is_wr[i]) apb_write(addrs[i], wdat[i], er);
      else          apb_read(addrs[i], rd, er);
      e = exp_q.pop_front();
      checks++;
      if (is_wr[i]) begin
        if (er !== e.err) begin failures++; $display("[TB] FAIL %s: got err=%b, want err=%b", e.name, er, e.err); end
      end else if (rd !== e.data || er !== e.err) begin
        failures++; $display("[TB] FAIL %s: got data=%h err=%b, want data=%h err=%b", e.name, rd, er, e.data, e.err);
      end
    end
  endtask

  task automatic test_cmd_combos();
    logic [31:0] rd; logic er;
    apb_write(ra(3, OFF_CMD), 32'h3, er);
    checks++; if (oRUNNING[3] !== 1'b0) begin failures++; $display("[TB] FAIL combo_stop_beats_start: got %b, want 0", oRUNNING[3]); end
    apb_write(ra(3, OFF_CMD), 32'h1, er);
    repeat (6) @(posedge iPCLK);
    #1 apb_read(ra(3, OFF_CURR), rd, er);
    checks++; if (rd !== 32'd1) begin failures++; $display("[TB] FAIL combo_pre_reset_curr: got %h, want 00000001", rd); end
    apb_write(ra(3, OFF_CMD), 32'h4, er);
    apb_read(ra(3, OFF_CURR), rd, er);
    checks++; if (rd !== 32'd0) begin failures++; $display("[TB] FAIL combo_reset_curr: got %h, want 00000000", rd); end
    checks++; if (oRUNNING !== 4'b1000) begin failures++; $display("[TB] FAIL combo_still_running: got %b, want 1000", oRUNNING); end
    apb_write(ra(3, OFF_CMD), 32'h2, er);
  endtask

  task automatic test_async_reset();
    logic [31:0] rd; logic er;
    apb_write(ra(1, OFF_CMD), 32'h1, er);
    checks++; if (oRUNNING !== 4'b0010) begin failures++; $display("[TB] FAIL async_pre_running: got %b, want 0010", oRUNNING); end
    #3 iPRESET = 1'b1;
    #1;
    checks++; if (oRUNNING !== 4'b0000) begin failures++; $display("[TB] FAIL async_running: got %b, want 0000", oRUNNING); end
    @(posedge iPCLK);
    #1 iPRESET = 1'b0;
    apb_read(ra(1, OFF_CURR), rd, er);
    checks++; if (rd !== 32'd0) begin failures++; $display("[TB] FAIL async_curr: got %h, want 00000000", rd); end
    apb_read(ra(2, OFF_MODE), rd, er);
    checks++; if (rd !== 32'd0) begin failures++; $display("[TB] FAIL async_mode: got %h, want 00000000", rd); end
    apb_read(ra(2, OFF_LOAD), rd, er);
    checks++; if (rd !== 32'd0) begin failures++; $display("[TB] FAIL async_load: got %h, want 00000000", rd); end
  endtask

  initial begin
    #100us;
    $display("[TB] FAIL watchdog: got timeout, want completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    test_reset();
    test_up_count();
    test_lap_fifo();
    test_count_down();
    test_errors();
    test_cmd_combos();
    test_async_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
